uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side sequencer for the UART receiver datapath: it watches the synchronized serial line, finds and qualifies start bits, and times the bit centres with an oversample tick. It drives the datapath's `sample`, `store` and `count1` controls, then reads back the shifted word. It checks parity and the stop bit, and hands each completed character to the consumer through a valid/ready handshake with overrun detection. It sits between the baud-tick generator and the receive FIFO/host interface.

## Interface
- `OVERSAMPLE`, 16: `os_tick` pulses per bit period; even, ≥4.
- `DATA_BITS`, 8: data bits per frame; datapath word is `DATA_BITS+1` wide.
- `clk` input 1: single clock; the datapath is clocked by the same `clk`.
- `reset` input 1: asynchronous, active-high; all state and outputs are cleared immediately.
- `os_tick` input 1: one-`clk` enable at `OVERSAMPLE`×baud; consecutive ticks are ≥3 `clk` apart.
- `rx_line` input 1: serial input, already synchronized to `clk`; idle is 1.
- `parity_en` input 1: 1 = frame carries a parity bit. Sampled at start detection and held for the frame.
- `parity_odd` input 1: 1 = odd parity, 0 = even. Sampled with `parity_en`.
- `rx_word` input `DATA_BITS+1`: datapath shift register; each `store` shifts right and loads the MSB.
- `sample` output 1: datapath enable that captures `rx_line`.
- `store` output 1: datapath enable that shifts the captured bit into `rx_word`.
- `count1` output 1: datapath period select; 1 = full bit, 0 = half bit.
- `busy` output 1: 1 whenever state ≠ IDLE.
- `rx_data` output `DATA_BITS`: received character.
- `rx_valid` output 1: `rx_data` and its flags are valid.
- `rx_ready` input 1: consumer accepts the character.
- `parity_err` output 1: parity mismatch; qualified by `rx_valid`.
- `frame_err` output 1: stop bit sampled as 0; qualified by `rx_valid`.
- `overrun` output 1: one-`clk` pulse when a finished frame is dropped.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Internal `tick_cnt` (log2 `OVERSAMPLE` bits) and `bit_cnt` (log2 `DATA_BITS`+1 bits).
- `count1`: 0 in IDLE and START, 1 in DATA, PARITY and STOP.
- IDLE: on `os_tick` with `rx_line`=0, go to START, set `tick_cnt`=0, and latch `parity_en`/`parity_odd`.
- START: each `os_tick` increments `tick_cnt`. On the tick where `tick_cnt`=`OVERSAMPLE/2-1`:
  - `rx_line`=0: go to DATA with `tick_cnt`=0 and `bit_cnt`=0.
  - `rx_line`=1: false start; return to IDLE. No `sample`/`store` is issued.
- DATA: each `os_tick` increments `tick_cnt`, which wraps at `OVERSAMPLE-1`→0. On the wrap tick, issue one `sample`/`store` pair and increment `bit_cnt`. After the `DATA_BITS`-th pair, go to PARITY if parity is latched, else STOP.
- PARITY: one more bit period with one `sample`/`store` pair, then go to STOP.
- STOP: on the wrap tick, read `rx_line` directly; no `sample`/`store`. Then complete the frame and return to IDLE in the same step, so a start bit immediately following is detected.
- Data extraction:
  - Parity on: 9 stores; data = `rx_word[DATA_BITS-1:0]` (LSB first); parity bit = `rx_word[DATA_BITS]`.
  - Parity off: `DATA_BITS` stores; data = `rx_word[DATA_BITS:1]`.
- Flags:
  - `parity_err` = `parity_en_latched` & (XOR-reduce(`rx_word`) ^ `parity_odd_latched`).
  - `frame_err` = ~`rx_line` at the stop centre.
- Completion: if `rx_valid`=0, or `rx_valid`&`rx_ready` in that same cycle, load `rx_data` and the flags and set `rx_valid`=1. Otherwise keep the old data and flags, drop the new frame, and pulse `overrun`.
- Handshake: `rx_valid` holds until `rx_valid`&`rx_ready`, then clears on the next edge unless a completion coincides. `rx_data` and the flags are stable while `rx_valid`=1.
- Reset mid-frame: return to IDLE. Latched parity configuration is discarded. No partial character is ever presented.

## Timing
- Reset values: `sample`, `store`, `count1`, `busy`, `rx_valid`, `parity_err`, `frame_err` and `overrun` = 0; `rx_data` = 0.
- All outputs are registered.
- `sample` is high for exactly the one `clk` following the edge that consumed the centre `os_tick`. `store` is high for exactly the next `clk`.
- `rx_valid` rises one `clk` after the edge consuming the stop-centre tick.
- Start-detect to first data sample: `OVERSAMPLE/2 + OVERSAMPLE` ticks.
- `os_tick` arriving while `sample`/`store` is pending is impossible, given the tick-spacing rule.

## Test plan
- 0x35, no parity, stop=1, `rx_ready`=1 → 8 `sample`/`store` pairs; `rx_data`=0x35; `parity_err`=0, `frame_err`=0; `rx_valid` high for one `clk`.
- 0x3C, even parity, parity bit 0 → `parity_err`=0. Same frame with parity bit 1 → `parity_err`=1, `rx_data`=0x3C. Odd parity, 0x3C, parity bit 1 → `parity_err`=0.
- 0x81, stop bit driven 0 → `frame_err`=1, `rx_data`=0x81, controller back in IDLE.
- `rx_line` low for 3 ticks then high → `busy` pulses; zero `sample`/`store` pulses; no `rx_valid`.
- Two back-to-back frames 0x11 then 0x22 with `rx_ready`=0 → `rx_data`=0x11 retained, one `overrun` pulse. Then `rx_ready`=1 for one `clk` → `rx_valid`=0.
- `reset` asserted after the 4th data store → all outputs 0 asynchronously. A frame of 0x5A after reset is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer: start qualification, bit-centre timing, parity/stop check, valid/ready hand-off
module uart_rx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 os_tick,
    input  logic                 rx_line,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic [DATA_BITS:0]   rx_word,
    output logic                 sample,
    output logic                 store,
    output logic                 count1,
    output logic                 busy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS) + 1;

    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;

    logic                 sample_q, sample_d;
    logic                 store_q, store_d;
    logic                 count1_q, count1_d;
    logic                 busy_q, busy_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    // Centre of a full bit period: the tick on which tick_cnt wraps.
    logic centre_tick;
    assign centre_tick = os_tick && (tick_cnt_q == TICK_LAST);

    // State register: FSM state, counters, latched parity config and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            sample_q     <= 1'b0;
            store_q      <= 1'b0;
            count1_q     <= 1'b0;
            busy_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            sample_q     <= sample_d;
            store_q      <= store_d;
            count1_q     <= count1_d;
            busy_q       <= busy_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // Next-state logic: start qualification at half bit, then full-bit stepping through data/parity/stop.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        unique case (state_q)
            S_IDLE: begin
                if (os_tick && !rx_line) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                    par_en_d   = parity_en;
                    par_odd_d  = parity_odd;
                end
            end
            S_START: begin
                if (os_tick) begin
                    if (tick_cnt_q == TICK_HALF) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_line ? S_IDLE : S_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            S_DATA: begin
                if (os_tick) begin
                    if (centre_tick) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = par_en_q ? S_PARITY : S_STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (os_tick) begin
                    if (centre_tick) begin
                        tick_cnt_d = '0;
                        state_d    = S_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            S_STOP: begin
                if (os_tick) begin
                    if (centre_tick) begin
                        tick_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: datapath strobes, status bits and the completion / overrun hand-off.
    always_comb begin
        sample_d     = centre_tick && ((state_q == S_DATA) || (state_q == S_PARITY));
        store_d      = sample_q;
        count1_d     = (state_d == S_DATA) || (state_d == S_PARITY) || (state_d == S_STOP);
        busy_d       = (state_d != S_IDLE);
        rx_valid_d   = rx_valid_q && !rx_ready;
        rx_data_d    = rx_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        if ((state_q == S_STOP) && centre_tick) begin
            if (!rx_valid_q || rx_ready) begin
                rx_valid_d   = 1'b1;
                rx_data_d    = par_en_q ? rx_word[DATA_BITS-1:0] : rx_word[DATA_BITS:1];
                parity_err_d = par_en_q & ((^rx_word) ^ par_odd_q);
                frame_err_d  = ~rx_line;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign sample     = sample_q;
    assign store      = store_q;
    assign count1     = count1_q;
    assign busy       = busy_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    localparam int OS = 16;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          os_tick;
    logic          rx_line;
    logic          parity_en;
    logic          parity_odd;
    logic [DB:0]   rx_word = '0;
    logic          sample;
    logic          store;
    logic          count1;
    logic          busy;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          parity_err;
    logic          frame_err;
    logic          overrun;

    int n_checks = 0;
    int n_errors = 0;

    int n_sample = 0, n_store = 0, n_ovr = 0, n_busy = 0, n_vrise = 0, n_vcyc = 0;
    logic          prev_valid = 1'b0;
    logic [DB-1:0] cap_data = '0;
    logic          cap_perr = 1'b0;
    logic          cap_ferr = 1'b0;
    logic          cap_bit = 1'b0;

    uart_rx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .reset      (reset),
        .os_tick    (os_tick),
        .rx_line    (rx_line),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rx_word    (rx_word),
        .sample     (sample),
        .store      (store),
        .count1     (count1),
        .busy       (busy),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Oversample tick every 4 clocks, changed on the falling edge
    initial begin
        int div;
        div = 0;
        os_tick = 1'b0;
        forever begin
            @(negedge clk);
            div = (div == 3) ? 0 : div + 1;
            os_tick = (div == 0);
        end
    end

    // Datapath model: sample captures the line, store shifts it in at the MSB
    always @(posedge clk) begin
        if (sample) cap_bit <= rx_line;
        if (store)  rx_word <= {cap_bit, rx_word[DB:1]};
    end

    // Activity monitor sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            n_sample += int'(sample);
            n_store  += int'(store);
            n_ovr    += int'(overrun);
            n_busy   += int'(busy);
            n_vcyc   += int'(rx_valid);
            if (rx_valid && !prev_valid) begin
                n_vrise++;
                cap_data = rx_data;
                cap_perr = parity_err;
                cap_ferr = frame_err;
            end
            prev_valid = rx_valid;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (os_tick !== 1'b1);
        end
    endtask

    task automatic send_bit(input logic v);
        @(negedge clk);
        rx_line = v;
        wait_ticks(OS);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic pen, input logic pbit, input logic stopv);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        send_bit(stopv);
        @(negedge clk);
        rx_line = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_sample"},   32'(sample),     32'd0);
        check_eq({tag, "_store"},    32'(store),      32'd0);
        check_eq({tag, "_count1"},   32'(count1),     32'd0);
        check_eq({tag, "_busy"},     32'(busy),       32'd0);
        check_eq({tag, "_valid"},    32'(rx_valid),   32'd0);
        check_eq({tag, "_data"},     32'(rx_data),    32'd0);
        check_eq({tag, "_perr"},     32'(parity_err), 32'd0);
        check_eq({tag, "_ferr"},     32'(frame_err),  32'd0);
        check_eq({tag, "_overrun"},  32'(overrun),    32'd0);
    endtask

    initial begin
        int s0, st0, v0, vc0, b0, o0;
        reset      = 1'b1;
        rx_line    = 1'b1;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        rx_ready   = 1'b1;
        repeat (4) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b0;
        wait_ticks(4);

        // 0x35, no parity, ready held high
        s0 = n_sample; st0 = n_store; v0 = n_vrise; vc0 = n_vcyc;
        send_frame(8'h35, 1'b0, 1'b0, 1'b1);
        wait_ticks(2);
        check_eq("t1_samples", 32'(n_sample - s0), 32'd8);
        check_eq("t1_stores",  32'(n_store - st0), 32'd8);
        check_eq("t1_vrise",   32'(n_vrise - v0),  32'd1);
        check_eq("t1_vcycles", 32'(n_vcyc - vc0),  32'd1);
        check_eq("t1_data",    32'(cap_data),      32'h35);
        check_eq("t1_perr",    32'(cap_perr),      32'd0);
        check_eq("t1_ferr",    32'(cap_ferr),      32'd0);

        // Parity cases on 0x3C (four ones)
        parity_en = 1'b1; parity_odd = 1'b0;
        st0 = n_store;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        wait_ticks(2);
        check_eq("t2_stores", 32'(n_store - st0), 32'd9);
        check_eq("t2_data",   32'(cap_data),      32'h3C);
        check_eq("t2_perr",   32'(cap_perr),      32'd0);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        wait_ticks(2);
        check_eq("t3_data",   32'(cap_data),      32'h3C);
        check_eq("t3_perr",   32'(cap_perr),      32'd1);
        parity_odd = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        wait_ticks(2);
        check_eq("t4_data",   32'(cap_data),      32'h3C);
        check_eq("t4_perr",   32'(cap_perr),      32'd0);
        parity_en = 1'b0; parity_odd = 1'b0;

        // Framing error on 0x81
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        wait_ticks(24);
        check_eq("t5_data", 32'(cap_data), 32'h81);
        check_eq("t5_ferr", 32'(cap_ferr), 32'd1);
        check_eq("t5_perr", 32'(cap_perr), 32'd0);
        check_eq("t5_idle", 32'(busy),     32'd0);

        // False start: low for 3 ticks only
        s0 = n_sample; st0 = n_store; v0 = n_vrise; b0 = n_busy;
        @(negedge clk);
        rx_line = 1'b0;
        wait_ticks(3);
        @(negedge clk);
        rx_line = 1'b1;
        wait_ticks(12);
        check_eq("t6_busy_seen", 32'(n_busy > b0),     32'd1);
        check_eq("t6_samples",   32'(n_sample - s0),   32'd0);
        check_eq("t6_stores",    32'(n_store - st0),   32'd0);
        check_eq("t6_vrise",     32'(n_vrise - v0),    32'd0);
        check_eq("t6_idle",      32'(busy),            32'd0);

        // Back-to-back frames with consumer stalled -> overrun
        rx_ready = 1'b0;
        o0 = n_ovr; v0 = n_vrise;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        wait_ticks(2);
        check_eq("t7_data",    32'(rx_data),       32'h11);
        check_eq("t7_valid",   32'(rx_valid),      32'd1);
        check_eq("t7_overrun", 32'(n_ovr - o0),    32'd1);
        check_eq("t7_vrise",   32'(n_vrise - v0),  32'd1);
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check_eq("t7_cleared", 32'(rx_valid), 32'd0);
        @(negedge clk);
        rx_ready = 1'b1;

        // Asynchronous reset after the 4th data store
        st0 = n_store; v0 = n_vrise;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        check_eq("t8_stores", 32'(n_store - st0), 32'd4);
        check_eq("t8_busy",   32'(busy),          32'd1);
        check_eq("t8_count1", 32'(count1),        32'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("t8_async");
        @(negedge clk);
        rx_line = 1'b1;
        reset   = 1'b0;
        wait_ticks(20);
        check_eq("t8_no_partial", 32'(n_vrise - v0), 32'd0);

        // Clean frame after reset
        v0 = n_vrise;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        wait_ticks(2);
        check_eq("t9_vrise", 32'(n_vrise - v0), 32'd1);
        check_eq("t9_data",  32'(cap_data),     32'h5A);
        check_eq("t9_perr",  32'(cap_perr),     32'd0);
        check_eq("t9_ferr",  32'(cap_ferr),     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
